// File: rtl/mem_req_pkg.sv
// Shared types for the memory request queue: request/response payloads
// and the helper that builds a response entry from a returned beat.
package mem_req_pkg;

   // Build widths of the payload structs; the top's width parameters default to these.
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              we;
   } mem_resp_t;

   // Write acks carry zero data so the requester never sees stale bus values.
   function automatic mem_resp_t make_resp(input logic we, input logic [DATA_W-1:0] rdata);
      mem_resp_t r;
      r.rdata = we ? '0 : rdata;
      r.we    = we;
      return r;
   endfunction

endpackage

// File: rtl/mem_req_queue_if.sv
// Bus bundle for mem_req_queue: requester channel, mux port and response channel.
// Signal suffixes are from the queue's point of view.
interface mem_req_queue_if
   import mem_req_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_W,
   parameter int unsigned DATA_WIDTH = DATA_W
);
   // requester side
   logic                    in_valid_i;
   logic                    in_ready_o;
   logic [ADDR_WIDTH-1:0]   in_addr_i;
   logic                    in_we_i;
   logic [DATA_WIDTH/8-1:0] in_be_i;
   logic [DATA_WIDTH-1:0]   in_wdata_i;
   // mux port side
   logic                    mem_req_o;
   logic                    mem_gnt_i;
   logic                    mem_rvalid_i;
   logic [ADDR_WIDTH-1:0]   mem_addr_o;
   logic                    mem_we_o;
   logic [DATA_WIDTH/8-1:0] mem_be_o;
   logic [DATA_WIDTH-1:0]   mem_wdata_o;
   logic [DATA_WIDTH-1:0]   mem_rdata_i;
   // response side
   logic                    resp_valid_o;
   logic                    resp_ready_i;
   logic [DATA_WIDTH-1:0]   resp_rdata_o;
   logic                    resp_we_o;

   // The queue itself
   modport slave (
      input  in_valid_i, in_addr_i, in_we_i, in_be_i, in_wdata_i,
      output in_ready_o,
      output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output resp_valid_o, resp_rdata_o, resp_we_o,
      input  resp_ready_i
   );

   // Environment driving the queue (requester + memory + response consumer)
   modport master (
      output in_valid_i, in_addr_i, in_we_i, in_be_i, in_wdata_i,
      input  in_ready_o,
      input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  resp_valid_o, resp_rdata_o, resp_we_o,
      output resp_ready_i
   );
endinterface

// File: rtl/mem_req_queue_fifo.sv
// Generic synchronous FIFO with registered storage, extra-bit pointers and
// an occupancy count. The head output reads zero while the FIFO is empty.
module generic_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             wr_en, rd_en;

   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign wr_en   = push_i && (!full_o || pop_i);
   assign rd_en   = pop_i && !empty_o;
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values, wrapping modulo 2*DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
      rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
   end

   // Pointer registers; reset empties the FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/mem_req_queue.sv
// Request queue in front of a low-priority RAM mux port. Requests are buffered
// and the head is held until granted; a request is only issued when a response
// slot is reserved, so responses are never dropped and return in order.
module mem_req_queue
   import mem_req_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_W,
   parameter int unsigned DATA_WIDTH = DATA_W,
   parameter int unsigned REQ_DEPTH  = 4,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   mem_req_queue_if.slave   bus,
   output logic             idle_o,
   output logic             err_o
);
   localparam int unsigned QCW = $clog2(REQ_DEPTH) + 1;
   localparam int unsigned RCW = $clog2(RESP_DEPTH) + 1;

   mem_req_t       req_in, req_head;
   mem_resp_t      resp_in, resp_head;
   logic           req_push, req_pop, req_full, req_empty;
   logic           resp_push, resp_pop, resp_full, resp_empty;
   logic [QCW-1:0] req_count;
   logic [RCW-1:0] resp_count;
   logic [RCW:0]   credit_used;
   logic           issue_ok;
   logic           outstanding_q, outstanding_d;
   logic           we_q, we_d;
   logic           err_q, err_d;
   logic           unused_req_state;

   assign unused_req_state = ^{req_count, resp_full};

   // ---------------- request path ----------------
   assign req_in.addr  = bus.in_addr_i;
   assign req_in.we    = bus.in_we_i;
   assign req_in.be    = bus.in_be_i;
   assign req_in.wdata = bus.in_wdata_i;

   assign bus.in_ready_o = !req_full;
   assign req_push       = bus.in_valid_i && !req_full;

   generic_fifo #(.WIDTH($bits(mem_req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (req_push),
      .data_i  (req_in),
      .pop_i   (req_pop),
      .data_o  (req_head),
      .full_o  (req_full),
      .empty_o (req_empty),
      .count_o (req_count)
   );

   // Slots already claimed: buffered responses (minus this cycle's pop) plus the one in flight.
   assign credit_used = {1'b0, resp_count} - {{RCW{1'b0}}, resp_pop} + {{RCW{1'b0}}, outstanding_q};
   assign issue_ok    = !req_empty && (credit_used < (RCW+1)'(RESP_DEPTH));

   assign bus.mem_req_o   = issue_ok;
   assign bus.mem_addr_o  = req_head.addr;
   assign bus.mem_we_o    = req_head.we;
   assign bus.mem_be_o    = req_head.be;
   assign bus.mem_wdata_o = req_head.wdata;
   assign req_pop         = issue_ok && bus.mem_gnt_i;

   // ---------------- response path ----------------
   assign resp_push = bus.mem_rvalid_i && outstanding_q;
   assign resp_in   = make_resp(we_q, bus.mem_rdata_i);
   assign resp_pop  = !resp_empty && bus.resp_ready_i;

   generic_fifo #(.WIDTH($bits(mem_resp_t)), .DEPTH(RESP_DEPTH)) u_resp_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (resp_push),
      .data_i  (resp_in),
      .pop_i   (resp_pop),
      .data_o  (resp_head),
      .full_o  (resp_full),
      .empty_o (resp_empty),
      .count_o (resp_count)
   );

   assign bus.resp_valid_o = !resp_empty;
   assign bus.resp_rdata_o = resp_head.rdata;
   assign bus.resp_we_o    = resp_head.we;

   // Track the single in-flight beat; any rvalid/outstanding disagreement is a sticky error
   always_comb begin
      outstanding_d = req_pop;
      we_d          = req_pop ? req_head.we : we_q;
      err_d         = err_q | (bus.mem_rvalid_i ^ outstanding_q);
   end

   // Issue-tracking registers; reset also discards the in-flight beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding_q <= 1'b0;
         we_q          <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         we_q          <= we_d;
         err_q         <= err_d;
      end
   end

   assign idle_o = req_empty && resp_empty && !outstanding_q;
   assign err_o  = err_q;

endmodule
